// File: rtl/sr_display_receiver.sv
// -----------------------------------------------------------------------------
// sr_display_receiver
//
// Rebuilds latched 7-segment display frames from the serial shift-register
// stream (data / shift clock / latch pins) of the calculator output driver.
// All three pins are sampled in the clk domain and edges are detected locally.
// Each latched frame is offered on a valid/ready interface.
//
// Configuration macro: SR_DISPLAY_RECEIVER_SYNC_EN
//   defined   -> 2-flop synchronizer per pin (action latency 2 clk cycles)
//   undefined -> single sampling register per pin (action latency 1 clk cycle)
//
// Ports:
//   clk             system clock, all state on rising edge
//   rst_n           asynchronous active-low reset
//   i_sr_data       serial data pin, MSB of first byte shifted first
//   i_sr_clk        shift clock pin, data captured on its rising edge
//   i_sr_latch      latch pin, rising edge ends the frame
//   o_frame         held frame, byte NUM_7_SEG_DISPLAYS-1 is the first shifted
//   o_frame_len_err held frame received a bit count other than FW
//   o_valid         held frame pending
//   i_ready         consumer accepts when o_valid & i_ready
//   o_overrun       sticky, latch edge arrived while a frame was pending
// -----------------------------------------------------------------------------
module sr_display_receiver #(
    parameter int NUM_7_SEG_DISPLAYS = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_sr_data,
    input  logic                            i_sr_clk,
    input  logic                            i_sr_latch,
    output logic [8*NUM_7_SEG_DISPLAYS-1:0] o_frame,
    output logic                            o_frame_len_err,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_overrun
);

    localparam int FW = 8 * NUM_7_SEG_DISPLAYS;
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    // Saturating bit-count increment: any count beyond FW only needs to
    // remember "too many", so it parks at FW+1.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
        if (value == CNT_SAT) begin
            sat_inc = CNT_SAT;
        end else begin
            sat_inc = value + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Pin bundle order: [2] data, [1] shift clock, [0] latch.
    logic [2:0]    pins_s;
    logic [1:0]    prev_r;
    logic [FW-1:0] sh_r;
    logic [FW-1:0] sh_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [FW-1:0] frame_r;
    logic          len_err_r;
    logic          valid_r;
    logic          overrun_r;
    logic          clk_rise_s;
    logic          latch_rise_s;
    logic          accept_s;

`ifdef SR_DISPLAY_RECEIVER_SYNC_EN
    logic [2:0] meta_r;
    logic [2:0] sync_r;

    // Two-flop synchronizer; data travels with the clock/latch lines so it
    // stays aligned with the detected shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 3'b000;
            sync_r <= 3'b000;
        end else begin
            meta_r <= {i_sr_data, i_sr_clk, i_sr_latch};
            sync_r <= meta_r;
        end
    end

    assign pins_s = sync_r;
`else
    logic [2:0] samp_r;

    // Single sampling stage for same-clock connection to the driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r <= 3'b000;
        end else begin
            samp_r <= {i_sr_data, i_sr_clk, i_sr_latch};
        end
    end

    assign pins_s = samp_r;
`endif

    // Previous-value registers for shift clock and latch edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 2'b00;
        end else begin
            prev_r <= pins_s[1:0];
        end
    end

    // Edge detection and next shift/count; a shift coinciding with a latch is
    // applied first so the latched frame and length check include that bit.
    always_comb begin
        clk_rise_s   = pins_s[1] & ~prev_r[1];
        latch_rise_s = pins_s[0] & ~prev_r[0];
        accept_s     = valid_r & i_ready;
        sh_next_s    = sh_r;
        cnt_next_s   = cnt_r;
        if (clk_rise_s) begin
            sh_next_s  = {sh_r[FW-2:0], pins_s[2]};
            cnt_next_s = sat_inc(cnt_r);
        end else begin
            sh_next_s  = sh_r;
            cnt_next_s = cnt_r;
        end
    end

    // Shift register and bit counter; sh is intentionally not cleared by a
    // latch, only the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r  <= {FW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else begin
            sh_r <= sh_next_s;
            if (latch_rise_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    // Output frame holding and valid/ready handshake. A latch in the same
    // cycle as an accept reloads immediately, so o_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r   <= {FW{1'b0}};
            len_err_r <= 1'b0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (latch_rise_s) begin
            if (!valid_r || accept_s) begin
                frame_r   <= sh_next_s;
                len_err_r <= (cnt_next_s != CNT_FULL);
                valid_r   <= 1'b1;
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= 1'b1;
            end
        end else if (accept_s) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_r;
            overrun_r <= overrun_r;
        end
    end

    assign o_frame         = frame_r;
    assign o_frame_len_err = len_err_r;
    assign o_valid         = valid_r;
    assign o_overrun       = overrun_r;

endmodule

// File: tb/tb_sr_display_receiver.sv
// -----------------------------------------------------------------------------
// tb_sr_display_receiver
//
// Scoreboard bench for sr_display_receiver. Stimulus tasks drive the serial
// pins and push the expected frame (last FW bits shifted since reset, plus a
// bit-count check) into a queue when a latch is issued; a monitor pops and
// compares whenever a frame is accepted. Honours SR_DISPLAY_RECEIVER_SYNC_EN
// for the expected latch-to-valid latency.
// -----------------------------------------------------------------------------
module tb_sr_display_receiver;

    localparam int N  = 5;
    localparam int FW = 8 * N;
`ifdef SR_DISPLAY_RECEIVER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [FW-1:0] frame;
        logic          err;
    } scb_item_t;

    logic          clk;
    logic          rst_n;
    logic          sr_data;
    logic          sr_clk;
    logic          sr_latch;
    logic [FW-1:0] frame;
    logic          len_err;
    logic          valid;
    logic          ready;
    logic          overrun;

    int        n_cmp = 0;
    int        n_err = 0;
    scb_item_t exp_q[$];
    bit        hist[$];
    int        cnt_bits = 0;

    sr_display_receiver #(.NUM_7_SEG_DISPLAYS(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_sr_data       (sr_data),
        .i_sr_clk        (sr_clk),
        .i_sr_latch      (sr_latch),
        .o_frame         (frame),
        .o_frame_len_err (len_err),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected frame: the last FW bits shifted since reset, oldest in the MSB.
    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        f = '0;
        foreach (hist[i]) f = (f << 1) | FW'(hist[i]);
        return f;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_latch(input bit drop);
        scb_item_t e;
        if (!drop) begin
            e.frame = model_frame();
            e.err   = (cnt_bits != FW);
            exp_q.push_back(e);
        end
        cnt_bits = 0;
    endtask

    task automatic shift_bit(input bit b, input bit with_latch);
        sr_data = b;
        sr_clk  = 1'b0;
        wait_cyc(2);
        sr_clk = 1'b1;
        hist.push_back(b);
        if (hist.size() > FW) void'(hist.pop_front());
        cnt_bits++;
        if (with_latch) begin
            sr_latch = 1'b1;
            model_latch(1'b0);
        end
        wait_cyc(2);
        if (with_latch) begin
            sr_latch = 1'b0;
            wait_cyc(2);
        end
    endtask

    task automatic send_bits(input logic [63:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(val[i], 1'b0);
    endtask

    task automatic send_rand_bits(input int nbits);
        for (int i = 0; i < nbits; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic latch(input bit drop);
        sr_latch = 1'b1;
        model_latch(drop);
        wait_cyc(2);
        sr_latch = 1'b0;
        wait_cyc(2);
    endtask

    task automatic do_reset();
        sr_data  = 1'b0;
        sr_clk   = 1'b0;
        sr_latch = 1'b0;
        rst_n    = 1'b0;
        hist.delete();
        cnt_bits = 0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    // Monitor: each accepted frame is compared against the scoreboard head.
    always @(negedge clk) begin
        scb_item_t e;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got %h expected none", frame);
            end else begin
                e = exp_q.pop_front();
                check("frame", 64'(frame), 64'(e.frame));
                check("len_err", 64'(len_err), 64'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sr_data  = 1'b0;
        sr_clk   = 1'b0;
        sr_latch = 1'b0;
        ready    = 1'b0;
        rst_n    = 1'b0;
        #1;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_frame", 64'(frame), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_len_err", 64'(len_err), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
        wait_cyc(1);

        // Known frame, with latch-to-valid latency and one-cycle valid
        ready = 1'b1;
        send_bits(64'hF00FAA553C, FW);
        sr_latch = 1'b1;
        model_latch(1'b0);
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) break;
        end
        check("latency", 64'(n - 1), 64'(LAT));
        check("first_frame_direct", 64'(frame), 64'hF00FAA553C);
        @(negedge clk);
        check("valid_falls", 64'(valid), 64'h0);
        check("overrun_clear", 64'(overrun), 64'h0);
        wait_cyc(1);
        sr_latch = 1'b0;
        wait_cyc(2);

        // Short and long frames
        send_rand_bits(39);
        latch(1'b0);
        send_rand_bits(45);
        latch(1'b0);

        // Overrun: second frame dropped while first is pending
        ready = 1'b0;
        send_rand_bits(FW);
        latch(1'b0);
        send_rand_bits(FW);
        latch(1'b1);
        wait_cyc(4);
        @(negedge clk);
        check("ovr_valid", 64'(valid), 64'h1);
        check("ovr_overrun", 64'(overrun), 64'h1);
        wait_cyc(1);
        ready = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        check("ovr_valid_after", 64'(valid), 64'h0);
        check("ovr_overrun_after", 64'(overrun), 64'h0);
        wait_cyc(1);

        // Latch in the same cycle as the 40th shift edge
        for (int i = 0; i < FW; i++) shift_bit(1'($urandom_range(0, 1)), i == FW - 1);
        wait_cyc(4);

        // Latch in the same cycle as an accept
        ready = 1'b0;
        send_rand_bits(FW);
        latch(1'b0);
        wait_cyc(4);
        send_rand_bits(FW);
        sr_latch = 1'b1;
        model_latch(1'b0);
        wait_cyc(LAT);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        @(negedge clk);
        check("la_valid_stays", 64'(valid), 64'h1);
        check("la_overrun", 64'(overrun), 64'h0);
        wait_cyc(1);
        sr_latch = 1'b0;
        wait_cyc(2);
        ready = 1'b1;
        wait_cyc(3);

        // Reset mid-frame, then a full frame
        send_rand_bits(20);
        do_reset();
        @(negedge clk);
        check("midrst_valid", 64'(valid), 64'h0);
        check("midrst_frame", 64'(frame), 64'h0);
        wait_cyc(1);
        send_bits(64'h0123456789, FW);
        latch(1'b0);

        // Randomized frames of varying length
        for (int f = 0; f < 12; f++) begin
            send_rand_bits(($urandom_range(0, 1) == 0) ? FW : $urandom_range(FW - 4, FW + 4));
            latch(1'b0);
        end

        wait_cyc(10);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_display_receiver.md
# sr_display_receiver

Deserializer for the 7-segment shift-register stream produced by the calculator's output driver. It samples the serial data, shift clock and latch pins in the system clock domain and rebuilds each latched display frame. Each frame is offered on a valid/ready interface. Used in the FPGA demo harness and the verification bench to check displayed values, and as a reusable receiver for chained display boards.

## Interface
Parameters:
- NUM_7_SEG_DISPLAYS, default 5: number of 8-bit display bytes per frame; frame width FW = 8*NUM_7_SEG_DISPLAYS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_sr_data  input  1  serial data pin; MSB of the first byte is shifted first.
- i_sr_clk  input  1  shift clock pin; data is captured on its rising edge.
- i_sr_latch  input  1  latch pin; a rising edge ends the frame.
- o_frame  output  FW  held frame; byte i = bits [8i+7:8i]; byte NUM_7_SEG_DISPLAYS-1 is the first byte shifted in.
- o_frame_len_err  output  1  set if the held frame received a bit count other than FW.
- o_valid  output  1  the held frame is pending.
- i_ready  input  1  consumer accepts the frame when o_valid & i_ready.
- o_overrun  output  1  sticky; set when a latch edge arrives while a frame is still pending.

## Operation
- Input path: the three pins are sampled through synchronizer stages (see Configuration). A previous-value register per line drives rising-edge detection for i_sr_clk and i_sr_latch. Data is delayed through the same stages so it stays aligned with the clock edge.
- Shift register sh[FW-1:0]: on each detected sr_clk rise, sh <= {sh[FW-2:0], data}.
- Bit counter cnt, width $clog2(FW+2):
  - increments on each shift and saturates at FW+1;
  - cleared on each latch edge.
- On a detected sr_latch rise:
  - If o_valid=0, or o_valid & i_ready in the same cycle:
    - o_frame <= sh;
    - o_frame_len_err <= (cnt != FW);
    - o_valid <= 1.
  - Else (frame still pending, not accepted): the new frame is dropped and o_frame and o_frame_len_err are unchanged; o_overrun <= 1.
  - cnt <= 0 in both cases. sh is not cleared.
- Accept (o_valid & i_ready) with no latch edge in the same cycle: o_valid <= 0 and o_overrun <= 0.
- Shift edge and latch edge in the same cycle: the shift is applied first. The latched frame includes the new bit, and the length check uses cnt+1.
- Reset values: o_frame=0, o_frame_len_err=0, o_valid=0, o_overrun=0, sh=0, cnt=0, all synchronizer and edge registers=0. Reset mid-frame discards the partial frame.
- The handshake follows the codebase rule: o_valid stays asserted and o_frame stays stable until accepted.

## Timing
- With synchronizers, an edge sampled high at clk edge k has its action registered at edge k+2. Without synchronizers, the action is registered at edge k+1.
- Latch-to-valid latency equals that action latency: o_valid is high in the cycle after the action edge.
- Input requirements:
  - each sr_clk and sr_latch high or low phase must last at least 2 clk cycles;
  - sr_data must be stable for at least 1 clk cycle before and after each sr_clk rising edge.
- Throughput: one frame per latch. The consumer may hold i_ready high continuously.

## Configuration
- SR_DISPLAY_RECEIVER_SYNC_EN defined: a 2-flop synchronizer is placed on each pin before the edge registers. Use this when the pins come from another domain or off-chip. Latency is 2 cycles.
- Undefined: a single sampling register per pin, intended for same-clock connection to the output driver. Latency is 1 cycle. All other behaviour is identical.

## Test plan
- Reset, then shift 40 bits of 0xF0_0F_AA_55_3C MSB-first and latch -> o_frame=40'hF00FAA553C, o_valid=1, o_frame_len_err=0, o_overrun=0; hold i_ready=1 -> o_valid falls after 1 cycle.
- Shift 39 bits, latch -> o_frame_len_err=1. Shift 45 bits, latch -> o_frame_len_err=1, and o_frame holds the last 40 bits shifted.
- Two frames with i_ready=0 -> first frame held, o_overrun=1; raise i_ready -> first frame accepted, o_valid=0, o_overrun=0.
- Latch edge in the same cycle as the 40th sr_clk rise -> frame includes the last bit, o_frame_len_err=0. Latch edge in the same cycle as an accept -> new frame loaded, o_valid stays 1, o_overrun=0.
- Assert rst_n=0 after 20 bits, release, then send a full frame of 40'h0123456789 -> o_frame=40'h0123456789, o_frame_len_err=0.
- Run the first scenario in both configurations -> latch-edge-to-o_valid latency is 2 cycles with SR_DISPLAY_RECEIVER_SYNC_EN and 1 cycle without.
